reg_wr_arb: RTL and testbench

//  Round-robin write arbiter sharing one output data register among REQ_NUM requesters.

---
 rtl/reg_arb_pkg.sv | 16 +
 rtl/arb_rr_pick.sv | 30 +++
 rtl/reg_wr_arb.sv | 85 ++++++++
 tb/tb_reg_wr_arb.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and helpers for the reg_wr_arb round-robin write arbiter.
package reg_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int CNT_WIDTH = 16;

    // Width of a requester index; never below one bit so a 1-wide id still exists.
    function automatic int id_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational round-robin picker, first valid requester at or after ptr, wrapping.
module arb_rr_pick
    import reg_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] id
);

    logic found;

    always_comb begin
        any   = |valid;
        id    = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (!found && valid[j]) begin
                id    = IW'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wr_arb.sv
// reg_wr_arb: round-robin write arbiter feeding one registered valid/ready output stage.
// Optional per-requester saturating grant counters when REG_WR_ARB_CNT_EN is defined.
module reg_wr_arb
    import reg_arb_pkg::*;
#(
    parameter int                    REQ_NUM    = 4,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [REQ_NUM-1:0]              i_req_valid,
    output logic [REQ_NUM-1:0]              o_req_ready,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]   i_req_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic [id_width(REQ_NUM)-1:0]    o_grant_id,
    output logic [REQ_NUM*CNT_WIDTH-1:0]    o_grant_cnt
);

    localparam int IW = id_width(REQ_NUM);

    state_t        state, state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic          any;
    logic          can_accept;
    logic          hs;

    arb_rr_pick #(.N(REQ_NUM), .IW(IW)) u_pick (
        .valid (i_req_valid),
        .ptr   (ptr),
        .any   (any),
        .id    (win)
    );

    // Nothing is acknowledged while reset is held, so no requester sees a lost handshake.
    assign can_accept  = (state == IDLE) | i_ready;
    assign hs          = can_accept & any & ~i_rst;
    assign o_req_ready = hs ? (REQ_NUM'(1) << win) : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = hs ? FULL : (i_ready ? IDLE : state);
    end

    always_comb begin
        o_valid = (state == FULL);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data     <= RST_VALUE;
            o_grant_id <= '0;
            ptr        <= '0;
        end else if (hs) begin
            o_data     <= i_req_data[win*DATA_WIDTH +: DATA_WIDTH];
            o_grant_id <= win;
            ptr        <= (win == IW'(REQ_NUM - 1)) ? '0 : win + 1'b1;
        end
    end

`ifdef REG_WR_ARB_CNT_EN
    for (genvar k = 0; k < REQ_NUM; k++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt;
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
                cnt <= '0;
            else if (hs && win == IW'(k) && cnt != '1)
                cnt <= cnt + 1'b1;
        end
        assign o_grant_cnt[k*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end
`else
    assign o_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_wr_arb.sv
// tb_reg_wr_arb: directed table-driven bench for reg_wr_arb (4 requesters, 32-bit words).
module tb_reg_wr_arb;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [3:0]   i_req_valid;
    logic [3:0]   o_req_ready;
    logic [127:0] i_req_data;
    logic         o_valid;
    logic         i_ready;
    logic [31:0]  o_data;
    logic [1:0]   o_grant_id;
    logic [63:0]  o_grant_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  valid;
        logic        rdy;
        logic [3:0]  exp_rr;
        logic        exp_v;
        logic [1:0]  exp_id;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl[13];

    reg_wr_arb #(.REQ_NUM(4), .DATA_WIDTH(32), .RST_VALUE(32'h0)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_data  (i_req_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_grant_id  (o_grant_id),
        .o_grant_cnt (o_grant_cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] d(input int k);
        return 32'hA5A5_0000 + k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input int n);
        @(negedge i_clk);
        i_req_valid = v.valid;
        i_ready     = v.rdy;
        #1 check($sformatf("vec%0d ready", n), 64'(o_req_ready), 64'(v.exp_rr));
        @(posedge i_clk);
        #1;
        check($sformatf("vec%0d valid", n), 64'(o_valid), 64'(v.exp_v));
        check($sformatf("vec%0d id", n), 64'(o_grant_id), 64'(v.exp_id));
        check($sformatf("vec%0d data", n), 64'(o_data), 64'(v.exp_d));
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, d(0)};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, d(1)};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, d(2)};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, d(3)};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, d(0)};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, d(0)};
        tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, d(2)};
        tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, d(2)};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, d(2)};
        tbl[9]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, d(3)};
        tbl[10] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, d(0)};
        tbl[11] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, d(3)};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, d(3)};

        i_rst       = 1'b1;
        i_req_valid = '0;
        i_ready     = 1'b0;
        i_req_data  = {d(3), d(2), d(1), d(0)};
        #3;
        check("reset valid", 64'(o_valid), 64'd0);
        check("reset data", 64'(o_data), 64'd0);
        check("reset id", 64'(o_grant_id), 64'd0);
        check("reset ready", 64'(o_req_ready), 64'd0);
        check("reset cnt", o_grant_cnt, 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int n = 0; n < 13; n++) apply(tbl[n], n);

        // Backpressure: fill with requester 0, then stall requester 1 for five cycles.
        @(negedge i_clk);
        i_req_valid = 4'b0001;
        i_ready     = 1'b0;
        @(posedge i_clk);
        #1 check("bp fill id", 64'(o_grant_id), 64'd0);
        @(negedge i_clk);
        i_req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp%0d ready", c), 64'(o_req_ready), 64'd0);
            check($sformatf("bp%0d data", c), 64'(o_data), 64'(d(0)));
            check($sformatf("bp%0d valid", c), 64'(o_valid), 64'd1);
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        #1 check("bp release ready", 64'(o_req_ready), 64'b0010);
        @(posedge i_clk);
        #1;
        check("bp release id", 64'(o_grant_id), 64'd1);
        check("bp release data", 64'(o_data), 64'(d(1)));
        check("bp release valid", 64'(o_valid), 64'd1);
        @(negedge i_clk);
        i_req_valid = '0;
        @(posedge i_clk);
        #1 check("bp drain valid", 64'(o_valid), 64'd0);

`ifdef REG_WR_ARB_CNT_EN
        @(negedge i_clk);
        i_req_valid = 4'b0001;
        repeat (70000) @(posedge i_clk);
        #1 check("cnt0 saturated", 64'(o_grant_cnt[15:0]), 64'hFFFF);
        @(negedge i_clk);
        i_req_valid = '0;
`else
        check("cnt disabled", o_grant_cnt, 64'd0);
`endif

        // Asynchronous reset while the stage holds a word.
        @(negedge i_clk);
        i_req_valid = 4'b0100;
        i_ready     = 1'b0;
        @(posedge i_clk);
        #1 check("pre-rst valid", 64'(o_valid), 64'd1);
        #2 i_rst = 1'b1;
        #1;
        check("rst valid", 64'(o_valid), 64'd0);
        check("rst data", 64'(o_data), 64'd0);
        check("rst id", 64'(o_grant_id), 64'd0);
        check("rst ready", 64'(o_req_ready), 64'd0);
        check("rst cnt", o_grant_cnt, 64'd0);
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_ready = 1'b1;
        #1 check("post-rst ready", 64'(o_req_ready), 64'b0100);
        @(posedge i_clk);
        #1 check("post-rst data", 64'(o_data), 64'(d(2)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
